// File: rtl/hazard_ctrl_if.sv
// Pipeline-side hazard bus: register ids and control bits in, stall/flush/forward controls out.
// The master is the pipeline datapath; the slave is the hazard controller.
interface hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic [4:0]       Rs1D;
  logic [4:0]       Rs2D;
  logic [4:0]       Rs1E;
  logic [4:0]       Rs2E;
  logic [4:0]       RdE;
  logic [4:0]       RdM;
  logic [4:0]       RdW;
  logic [1:0]       ResultSrcE;
  logic             RegWriteM;
  logic             RegWriteW;
  logic             PCSrcE;
  logic             MemReqM;
  logic             MemAckM;
  logic [1:0]       ForwardAE;
  logic [1:0]       ForwardBE;
  logic             StallF;
  logic             StallD;
  logic             StallE;
  logic             StallM;
  logic             FlushD;
  logic             FlushE;
  logic             FlushW;
  logic             MemErr;
  logic [CNT_W-1:0] StallCyc;
  logic [CNT_W-1:0] FlushCnt;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, ResultSrcE, RegWriteM, RegWriteW,
    output PCSrcE, MemReqM, MemAckM,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
    input  MemErr, StallCyc, FlushCnt
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, ResultSrcE, RegWriteM, RegWriteW,
    input  PCSrcE, MemReqM, MemAckM,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
    output MemErr, StallCyc, FlushCnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline hazard controller: load-use stalls, branch flushes, data-memory waits
// with timeout abort, E-stage forwarding selects and saturating stall/flush counters.
module hazard_ctrl #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        CLK,
  input  logic        RST,
  hazard_ctrl_if.slave hz
);

  localparam int unsigned WaitW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StInit, StRun, StMemWait} state_e;

  state_e           state_q, state_d;
  logic [WaitW-1:0] cnt_q, cnt_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_cyc_q, stall_cyc_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic memstall, load_use;
  logic stall_f, stall_d, stall_e, stall_m;
  logic flush_d, flush_e, flush_w;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic [4:0] rd_m,
                                         input logic wr_m, input logic [4:0] rd_w,
                                         input logic wr_w);
    if (rs != 5'd0 && wr_m && rd_m == rs)      return 2'b10;
    else if (rs != 5'd0 && wr_w && rd_w == rs) return 2'b01;
    else                                       return 2'b00;
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_err_d = mem_err_q;
    memstall  = 1'b0;
    unique case (state_q)
      StInit: state_d = StRun;
      StRun: begin
        if (hz.MemReqM && !hz.MemAckM) begin
          memstall = 1'b1;
          state_d  = StMemWait;
          cnt_d    = WaitW'(1);
        end
      end
      StMemWait: begin
        if (hz.MemAckM) begin
          state_d = StRun;
        end else if (cnt_q == WaitLast) begin
          // Abort: release the pipeline this cycle and flag the error.
          state_d   = StRun;
          mem_err_d = 1'b1;
        end else begin
          memstall = 1'b1;
          cnt_d    = cnt_q + WaitW'(1);
        end
      end
      default: state_d = StInit;
    endcase
  end

  assign load_use = (hz.ResultSrcE == 2'b01) && (hz.RdE != 5'd0) &&
                    ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));

  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_w = 1'b0;
    if (state_q == StInit) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (memstall) begin
      // Whole front of the pipe holds; branch and load-use resolve after the ack.
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else if (hz.PCSrcE) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (load_use) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  always_comb begin
    stall_cyc_d = stall_cyc_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_f && stall_cyc_q != {CNT_W{1'b1}}) begin
      stall_cyc_d = stall_cyc_q + CNT_W'(1);
    end
    if (hz.PCSrcE && !memstall && flush_cnt_q != {CNT_W{1'b1}}) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= StInit;
      cnt_q       <= '0;
      mem_err_q   <= 1'b0;
      stall_cyc_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_err_q   <= mem_err_d;
      stall_cyc_q <= stall_cyc_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.ForwardAE = fwd_sel(hz.Rs1E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW);
  assign hz.ForwardBE = fwd_sel(hz.Rs2E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW);
  assign hz.StallF    = stall_f;
  assign hz.StallD    = stall_d;
  assign hz.StallE    = stall_e;
  assign hz.StallM    = stall_m;
  assign hz.FlushD    = flush_d;
  assign hz.FlushE    = flush_e;
  assign hz.FlushW    = flush_w;
  assign hz.MemErr    = mem_err_q;
  assign hz.StallCyc  = stall_cyc_q;
  assign hz.FlushCnt  = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed hazard scenarios then random traffic, all outputs checked
// every cycle against a behavioural model of the pipeline-control rules.
module tb_hazard_ctrl;
  localparam int unsigned CntW    = 4;
  localparam int unsigned Timeout = 4;
  localparam int unsigned CntMax  = (1 << CntW) - 1;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  hazard_ctrl_if #(.CNT_W(CntW)) bus ();

  hazard_ctrl #(.CNT_W(CntW), .TIMEOUT(Timeout)) dut (
    .CLK (clk),
    .RST (rst_n),
    .hz  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: in_init, whether a memory access is being waited on, and how many
  // stall cycles that access has already cost.
  bit m_init;
  bit m_waiting;
  int m_stalled;
  bit m_err;
  int m_stall_cyc;
  int m_flush_cnt;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int fwd_model(input int rs);
    if (rs != 0 && bus.RegWriteM && int'(bus.RdM) == rs) return 2;
    if (rs != 0 && bus.RegWriteW && int'(bus.RdW) == rs) return 1;
    return 0;
  endfunction

  task automatic model_reset();
    m_init      = 1'b1;
    m_waiting   = 1'b0;
    m_stalled   = 0;
    m_err       = 1'b0;
    m_stall_cyc = 0;
    m_flush_cnt = 0;
  endtask

  task automatic zero_inputs();
    bus.Rs1D = '0; bus.Rs2D = '0; bus.Rs1E = '0; bus.Rs2E = '0;
    bus.RdE = '0; bus.RdM = '0; bus.RdW = '0; bus.ResultSrcE = '0;
    bus.RegWriteM = 1'b0; bus.RegWriteW = 1'b0; bus.PCSrcE = 1'b0;
    bus.MemReqM = 1'b0; bus.MemAckM = 1'b0;
  endtask

  task automatic rand_inputs();
    bus.Rs1D = 5'($urandom_range(0, 3));
    bus.Rs2D = 5'($urandom_range(0, 3));
    bus.Rs1E = 5'($urandom_range(0, 3));
    bus.Rs2E = 5'($urandom_range(0, 3));
    bus.RdE  = 5'($urandom_range(0, 3));
    bus.RdM  = 5'($urandom_range(0, 3));
    bus.RdW  = 5'($urandom_range(0, 3));
    bus.ResultSrcE = 2'($urandom_range(0, 3));
    bus.RegWriteM  = 1'($urandom_range(0, 1));
    bus.RegWriteW  = 1'($urandom_range(0, 1));
    bus.PCSrcE     = ($urandom_range(0, 3) == 0);
    bus.MemReqM    = ($urandom_range(0, 2) == 0);
    bus.MemAckM    = ($urandom_range(0, 2) == 0);
  endtask

  // Called just after a falling edge with inputs applied; checks, advances the model,
  // then waits for the next falling edge.
  task automatic run_cycle();
    bit mem_hold, load_use;
    bit e_sf, e_sd, e_se, e_sm, e_fd, e_fe, e_fw;
    #1;
    if (m_init)          mem_hold = 1'b0;
    else if (!m_waiting) mem_hold = bus.MemReqM && !bus.MemAckM;
    else                 mem_hold = !bus.MemAckM && (m_stalled < Timeout - 1);
    load_use = (bus.ResultSrcE == 2'b01) && (bus.RdE != 0) &&
               (bus.RdE == bus.Rs1D || bus.RdE == bus.Rs2D);
    {e_sf, e_sd, e_se, e_sm, e_fd, e_fe, e_fw} = '0;
    if (m_init) begin
      e_fd = 1'b1; e_fe = 1'b1;
    end else if (mem_hold) begin
      {e_sf, e_sd, e_se, e_sm, e_fw} = '1;
    end else if (bus.PCSrcE) begin
      e_fd = 1'b1; e_fe = 1'b1;
    end else if (load_use) begin
      e_sf = 1'b1; e_sd = 1'b1; e_fe = 1'b1;
    end
    check_eq("ForwardAE", 32'(bus.ForwardAE), 32'(fwd_model(int'(bus.Rs1E))));
    check_eq("ForwardBE", 32'(bus.ForwardBE), 32'(fwd_model(int'(bus.Rs2E))));
    check_eq("StallF",   32'(bus.StallF), 32'(e_sf));
    check_eq("StallD",   32'(bus.StallD), 32'(e_sd));
    check_eq("StallE",   32'(bus.StallE), 32'(e_se));
    check_eq("StallM",   32'(bus.StallM), 32'(e_sm));
    check_eq("FlushD",   32'(bus.FlushD), 32'(e_fd));
    check_eq("FlushE",   32'(bus.FlushE), 32'(e_fe));
    check_eq("FlushW",   32'(bus.FlushW), 32'(e_fw));
    check_eq("MemErr",   32'(bus.MemErr), 32'(m_err));
    check_eq("StallCyc", 32'(bus.StallCyc), 32'(m_stall_cyc));
    check_eq("FlushCnt", 32'(bus.FlushCnt), 32'(m_flush_cnt));
    if (e_sf && m_stall_cyc < CntMax) m_stall_cyc++;
    if (bus.PCSrcE && !mem_hold && m_flush_cnt < CntMax) m_flush_cnt++;
    if (m_init) begin
      m_init = 1'b0;
    end else if (!m_waiting) begin
      if (mem_hold) begin m_waiting = 1'b1; m_stalled = 1; end
    end else if (bus.MemAckM) begin
      m_waiting = 1'b0;
    end else if (m_stalled == Timeout - 1) begin
      m_waiting = 1'b0;
      m_err     = 1'b1;
    end else begin
      m_stalled++;
    end
    @(negedge clk);
  endtask

  task automatic check_in_reset();
    check_eq("rst_StallF",   32'(bus.StallF), 32'd0);
    check_eq("rst_StallM",   32'(bus.StallM), 32'd0);
    check_eq("rst_FlushW",   32'(bus.FlushW), 32'd0);
    check_eq("rst_FlushD",   32'(bus.FlushD), 32'd1);
    check_eq("rst_MemErr",   32'(bus.MemErr), 32'd0);
    check_eq("rst_StallCyc", 32'(bus.StallCyc), 32'd0);
    check_eq("rst_FlushCnt", 32'(bus.FlushCnt), 32'd0);
  endtask

  initial begin
    zero_inputs();
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1 check_in_reset();
    @(negedge clk);
    rst_n = 1'b1;
    run_cycle();

    // Load x5 in E feeding D, then the dependent instruction forwards from W.
    bus.RdE = 5'd5; bus.ResultSrcE = 2'b01; bus.Rs1D = 5'd5;
    run_cycle();
    zero_inputs();
    bus.Rs1E = 5'd5; bus.RdW = 5'd5; bus.RegWriteW = 1'b1;
    run_cycle();

    // M and W both write x7: M wins; x0 never forwards.
    zero_inputs();
    bus.RdM = 5'd7; bus.RdW = 5'd7; bus.RegWriteM = 1'b1; bus.RegWriteW = 1'b1;
    bus.Rs1E = 5'd7;
    run_cycle();

    // Three-cycle memory wait then ack.
    zero_inputs();
    bus.MemReqM = 1'b1;
    repeat (3) run_cycle();
    bus.MemAckM = 1'b1;
    run_cycle();
    zero_inputs();
    run_cycle();

    // Branch during a memory stall is deferred until the ack.
    bus.MemReqM = 1'b1; bus.PCSrcE = 1'b1;
    repeat (2) run_cycle();
    bus.MemAckM = 1'b1;
    run_cycle();
    zero_inputs();
    run_cycle();

    // Access that never acks: timeout abort sets the sticky error.
    bus.MemReqM = 1'b1;
    repeat (3) run_cycle();
    run_cycle();
    zero_inputs();
    repeat (3) run_cycle();

    // Long load-use stall saturates StallCyc.
    bus.RdE = 5'd3; bus.ResultSrcE = 2'b01; bus.Rs2D = 5'd3;
    repeat (20) run_cycle();
    zero_inputs();

    // Reset in the middle of a memory wait.
    bus.MemReqM = 1'b1;
    repeat (2) run_cycle();
    rst_n = 1'b0;
    #1 check_in_reset();
    model_reset();
    @(negedge clk);
    zero_inputs();
    rst_n = 1'b1;
    run_cycle();

    for (int i = 0; i < 1500; i++) begin
      rand_inputs();
      run_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
